i2s_tx_serializer: RTL and testbench

// Downstream stage of the BRAM sample player: accepts 16-bit signed samples
// (player/volume output, valid handshake) on the mclk domain, generates BCLK
// and LRCLK by dividing mclk, and serialises each sample onto SDATA in Philips
// I2S format (MSB first, one-BCLK delay after the LRCLK edge). The source is

---
 rtl/i2s_tx_serializer.sv | 81 ++++++++
 tb/tb_i2s_tx_serializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers one mono sample and shifts it out in Philips I2S format on both channel slots
module i2s_tx_serializer #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS = 32,
  parameter int MCLK_PER_BCLK = 4
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   frame_start,
  output logic                   underrun
);
  localparam int DW = MCLK_PER_BCLK > 2 ? $clog2(MCLK_PER_BCLK) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt, pos, idx;
  logic [SAMPLE_BITS-1:0] pending, frame_reg, frame_nxt, shifted;
  logic tick, load, first, ready_en, pending_full, accept, sdata_nxt;
  // divider, bit position and the data bit that the next tick will present
  always_comb begin
    tick = enable && div_cnt == DW'(MCLK_PER_BCLK - 1);
    load = tick && (first || bit_cnt == BW'(2 * SLOT_BITS - 1));
    div_nxt = !enable || tick ? '0 : div_cnt + DW'(1);
    bit_nxt = !enable || load ? '0 : tick ? bit_cnt + BW'(1) : bit_cnt;
    pos = bit_nxt >= BW'(SLOT_BITS) ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
    frame_nxt = load && pending_full ? pending : frame_reg;
    idx = BW'(SAMPLE_BITS) - pos;
    shifted = frame_nxt >> idx;
    sdata_nxt = pos != '0 && pos <= BW'(SAMPLE_BITS) && shifted[0];
    sample_ready = ready_en && !pending_full;
    accept = sample_valid && sample_ready;
  end
  // serial clock counters; first marks that the next tick starts a fresh frame
  always_ff @(posedge mclk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      first <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      first <= !enable || (first && !tick);
    end
  end
  // one-entry pending buffer and the frame being shifted out
  always_ff @(posedge mclk) begin
    if (rst) begin
      pending <= '0;
      pending_full <= 1'b0;
      frame_reg <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      frame_reg <= frame_nxt;
      pending <= accept ? sample_in : pending;
      pending_full <= accept || (pending_full && !load);
    end
  end
  // registered pin drivers and frame pulses
  always_ff @(posedge mclk) begin
    if (rst) begin
      bclk <= 1'b0;
      lrclk <= 1'b0;
      sdata <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      bclk <= div_nxt >= DW'(MCLK_PER_BCLK / 2);
      lrclk <= bit_nxt >= BW'(SLOT_BITS);
      sdata <= !enable ? 1'b0 : tick ? sdata_nxt : sdata;
      frame_start <= load;
      underrun <= load && !pending_full;
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: vector table, corner sequences and random traffic against a frame-timing model
module tb_i2s_tx_serializer;
  localparam int SB = 16, S = 32, M = 4, FR = 2 * S * M;
  logic mclk = 0, rst = 1, enable = 0, sample_valid = 0;
  logic [15:0] sample_in = 0;
  logic sample_ready, bclk, lrclk, sdata, frame_start, underrun;
  int total = 0, bad = 0;
  logic m_pf = 0, m_ren = 0, m_fs = 0, m_ur = 0, acc_dut = 0, prev_bclk = 0, bclk_rise = 0, cap_pad_bad = 0;
  logic [15:0] m_pend = 0, m_frame = 0, cap_word = 0;
  int n = 0, m_bit = 0, cyc = 0, load_cyc = 0, acc_cyc = 0, fs_cyc = 0, cap_pos = 0;
  typedef struct {logic push; logic [15:0] val; logic exp_ur; logic [15:0] exp_word;} vec_t;
  vec_t tbl[7];

  i2s_tx_serializer dut (.mclk(mclk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .frame_start(frame_start), .underrun(underrun));

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic a, ld;
    int t, p;
    ld = 0;
    a = sample_valid && m_ren && !m_pf;
    acc_dut = sample_valid && sample_ready;
    @(posedge mclk);
    cyc++;
    if (rst) begin
      m_pf = 0; m_pend = 0; m_frame = 0; m_ren = 0; n = 0;
    end else begin
      m_ren = 1;
      n = enable ? n + 1 : 0;
      ld = enable && n >= M && (n - M) % FR == 0;
      if (ld) load_cyc = cyc;
      if (ld && !m_pf) ld = 1;
      m_ur = ld && !m_pf;
      if (ld && m_pf) begin m_frame = m_pend; m_pf = 0; end
      if (a) begin m_pend = sample_in; m_pf = 1; acc_cyc = cyc; end
    end
    m_fs = ld;
    if (rst) m_ur = 0;
    @(negedge mclk);
    t = n / M;
    m_bit = t == 0 ? 0 : (t - 1) % (2 * S);
    p = m_bit % S;
    chk("sample_ready", sample_ready, m_ren && !m_pf);
    chk("bclk", bclk, (n % M) >= M / 2);
    chk("lrclk", lrclk, m_bit >= S);
    chk("sdata", sdata, (t >= 1 && p >= 1 && p <= SB) ? m_frame[SB-p] : 1'b0);
    chk("frame_start", frame_start, m_fs);
    chk("underrun", underrun, m_ur);
    bclk_rise = bclk && !prev_bclk;
    if (frame_start) begin
      cap_pos = 0; cap_pad_bad = 0; fs_cyc = cyc;
    end else if (bclk_rise) begin
      if (cap_pos >= 1 && cap_pos <= SB) cap_word[SB-cap_pos] = sdata;
      else if (cap_pos < S && sdata) cap_pad_bad = 1;
      cap_pos++;
    end
    prev_bclk = bclk;
  endtask

  task automatic wait_load();
    int k = 0;
    do begin cycle(); k++; end while (!frame_start && k < FR + 16);
    chk("load_seen", frame_start, 1);
  endtask

  task automatic wait_word(input string nm, input logic [15:0] exp);
    int k = 0;
    while (cap_pos < S && k < FR + 16) begin cycle(); k++; end
    chk({nm, "_word"}, cap_word, exp);
    chk({nm, "_pad"}, cap_pad_bad, 0);
  endtask

  task automatic push(input logic [15:0] v);
    int k = 0;
    sample_valid = 1; sample_in = v;
    do begin cycle(); k++; end while (!acc_dut && k < FR + 16);
    chk("push_accept", acc_dut, 1);
    sample_valid = 0;
  endtask

  initial begin
    int k, prev_fs, rises;
    tbl[0] = '{1, 16'hA5F0, 0, 16'hA5F0};
    tbl[1] = '{0, 16'h0000, 1, 16'hA5F0};
    tbl[2] = '{1, 16'h8001, 0, 16'h8001};
    tbl[3] = '{1, 16'h0000, 0, 16'h0000};
    tbl[4] = '{1, 16'hFFFF, 0, 16'hFFFF};
    tbl[5] = '{0, 16'h0000, 1, 16'hFFFF};
    tbl[6] = '{1, 16'h8000, 0, 16'h8000};
    repeat (3) cycle();
    chk("rst_pins", {bclk, lrclk, sdata, sample_ready, frame_start, underrun}, 0);
    rst = 0;
    cycle();
    chk("ready_after_rst", sample_ready, 1);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].push) push(tbl[i].val);
      enable = 1;
      prev_fs = fs_cyc;
      wait_load();
      chk("tbl_underrun", underrun, tbl[i].exp_ur);
      if (i > 0) chk("frame_period", fs_cyc - prev_fs, FR);
      wait_word("tbl", tbl[i].exp_word);
    end
    wait_load();
    wait_word("tbl_tail", 16'h8000);
    sample_valid = 1; sample_in = 16'h1234;
    k = 0;
    do begin cycle(); k++; end while (!acc_dut && k < FR + 16);
    chk("t4_first_accept", acc_dut, 1);
    chk("t4_ready_low", sample_ready, 0);
    sample_in = 16'h5678;
    k = 0;
    do begin cycle(); k++; end while (!acc_dut && k < 2 * FR);
    chk("t4_second_accept", acc_dut, 1);
    chk("t4_accept_after_load", cyc - fs_cyc, 1);
    sample_valid = 0;
    wait_word("t4_a", 16'h1234);
    wait_load();
    chk("t4_underrun", underrun, 0);
    wait_word("t4_b", 16'h5678);
    k = 0;
    while (!(n + 1 >= M && (n + 1 - M) % FR == 0) && k < FR + 16) begin cycle(); k++; end
    sample_valid = 1; sample_in = 16'h7FFF;
    cycle();
    sample_valid = 0;
    chk("t5_underrun", underrun, 1);
    chk("t5_frame_start", frame_start, 1);
    chk("t5_accept_same_edge", acc_dut, 1);
    wait_word("t5_repeat", 16'h5678);
    wait_load();
    chk("t5_underrun_next", underrun, 0);
    wait_word("t5_new", 16'h7FFF);
    wait_load();
    push(16'h3C3C);
    k = 0;
    while (m_bit != 20 && k < FR + 16) begin cycle(); k++; end
    enable = 0;
    cycle();
    chk("t6_drop_pins", {bclk, lrclk, sdata}, 0);
    repeat (5) begin cycle(); chk("t6_idle_pulses", {frame_start, underrun}, 0); end
    enable = 1;
    prev_fs = cyc;
    wait_load();
    chk("t6_reen_latency", cyc - prev_fs, M);
    chk("t6_underrun", underrun, 0);
    rises = 0; k = 0;
    do begin cycle(); k++; if (bclk_rise && !lrclk) rises++; end while (!lrclk && k < FR);
    chk("t6_left_bclks", rises, S);
    wait_word("t6", 16'h3C3C);
    for (int i = 0; i < 5000; i++) begin
      sample_valid = $urandom_range(0, 3) == 0;
      sample_in = 16'($urandom);
      if (enable && $urandom_range(0, 1499) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
